// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
//   Machine-mode CSR register file that sits directly after the execute
//   stage. It takes execute's flopped CSR write-back, trap capture and retire
//   strobe, offers a combinational read port to decode, and hands mstatus,
//   mtvec and mepc back to execute for trap entry/return. It also owns the
//   64-bit mcycle/minstret counters.
//
// Ports
//   clk               clock, all state updates on the rising edge
//   reset             asynchronous, active-high reset
//   csr_rd_adr_i      CSR read address from decode
//   csr_rd_data_o     read data for csr_rd_adr_i (combinational from state)
//   csr_rd_illegal_o  high when csr_rd_adr_i is not an implemented CSR
//   csr_wbk_v_i       CSR write enable
//   csr_adr_i         CSR write address
//   csr_data_i        CSR write data
//   exception_i       trap taken this cycle
//   mcause_i          trap cause
//   mtval_i           trap value
//   mepc_i            faulting PC
//   core_mode_i       privilege mode before the trap
//   instret_i         one instruction retired this cycle
//   mstatus_q_o       current mstatus
//   mtvec_q_o         current mtvec
//   mepc_q_o          current mepc
//
// Handshake / timing: there is no valid/ready flow control. Every input is
// a single-cycle qualifier sampled on the rising edge; the result of a write,
// trap or counter increment on edge N is visible on every output after N.
// Reads never bypass a same-cycle write (execute forwards on its own).
// ---------------------------------------------------------------------------
module csr_file #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  MTVEC_RST = 32'h0000_0000,
  parameter logic [XLEN-1:0]  MISA_VAL  = 32'h4000_0100,
  parameter logic [XLEN-1:0]  HART_ID   = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [11:0]     csr_rd_adr_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_rd_illegal_o,
  input  logic            csr_wbk_v_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [1:0]      core_mode_i,
  input  logic            instret_i,
  output logic [XLEN-1:0] mstatus_q_o,
  output logic [XLEN-1:0] mtvec_q_o,
  output logic [XLEN-1:0] mepc_q_o
);

  // -------------------------------------------------------------------------
  // CSR addresses
  // -------------------------------------------------------------------------
  localparam logic [11:0] ADR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADR_MISA      = 12'h301;
  localparam logic [11:0] ADR_MIE       = 12'h304;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MTVAL     = 12'h343;
  localparam logic [11:0] ADR_MIP       = 12'h344;
  localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADR_MHARTID   = 12'hF14;

  // mstatus.MPP comes out of reset as machine mode.
  localparam logic [1:0]  MPP_RST = 2'b11;

  // -------------------------------------------------------------------------
  // Architectural state
  // -------------------------------------------------------------------------
  logic                   r_mstatus_mie;
  logic                   r_mstatus_mpie;
  logic [1:0]             r_mstatus_mpp;
  logic [XLEN-1:0]        r_mie;
  logic [XLEN-1:2]        r_mtvec;     // direct mode only, bits [1:0] are 0
  logic [XLEN-1:0]        r_mscratch;
  logic [XLEN-1:2]        r_mepc;      // always word aligned
  logic [XLEN-1:0]        r_mcause;
  logic [XLEN-1:0]        r_mtval;
  logic [2*XLEN-1:0]      r_mcycle;
  logic [2*XLEN-1:0]      r_minstret;

  // -------------------------------------------------------------------------
  // Write decode. A trap in the same cycle drops the CSR write completely,
  // including its effect on the counters.
  // -------------------------------------------------------------------------
  logic w_wr;
  logic w_wr_mstatus;
  logic w_wr_mie;
  logic w_wr_mtvec;
  logic w_wr_mscratch;
  logic w_wr_mepc;
  logic w_wr_mcause;
  logic w_wr_mtval;
  logic w_wr_mcycle_lo;
  logic w_wr_mcycle_hi;
  logic w_wr_minstret_lo;
  logic w_wr_minstret_hi;

  assign w_wr             = csr_wbk_v_i & ~exception_i;
  assign w_wr_mstatus     = w_wr & (csr_adr_i == ADR_MSTATUS);
  assign w_wr_mie         = w_wr & (csr_adr_i == ADR_MIE);
  assign w_wr_mtvec       = w_wr & (csr_adr_i == ADR_MTVEC);
  assign w_wr_mscratch    = w_wr & (csr_adr_i == ADR_MSCRATCH);
  assign w_wr_mepc        = w_wr & (csr_adr_i == ADR_MEPC);
  assign w_wr_mcause      = w_wr & (csr_adr_i == ADR_MCAUSE);
  assign w_wr_mtval       = w_wr & (csr_adr_i == ADR_MTVAL);
  assign w_wr_mcycle_lo   = w_wr & (csr_adr_i == ADR_MCYCLE);
  assign w_wr_mcycle_hi   = w_wr & (csr_adr_i == ADR_MCYCLEH);
  assign w_wr_minstret_lo = w_wr & (csr_adr_i == ADR_MINSTRET);
  assign w_wr_minstret_hi = w_wr & (csr_adr_i == ADR_MINSTRETH);

  // -------------------------------------------------------------------------
  // mstatus: trap entry stacks MIE into MPIE and records the previous mode.
  // mret arrives as an ordinary write of the restored value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mstatus_mpp  <= MPP_RST;
    end else if (exception_i) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mpp  <= core_mode_i;
    end else if (w_wr_mstatus) begin
      r_mstatus_mie  <= csr_data_i[3];
      r_mstatus_mpie <= csr_data_i[7];
      r_mstatus_mpp  <= csr_data_i[12:11];
    end
  end

  // -------------------------------------------------------------------------
  // Trap capture registers (also software writable)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (exception_i) begin
      r_mepc   <= mepc_i[XLEN-1:2];
      r_mcause <= mcause_i;
      r_mtval  <= mtval_i;
    end else begin
      if (w_wr_mepc)   r_mepc   <= csr_data_i[XLEN-1:2];
      if (w_wr_mcause) r_mcause <= csr_data_i;
      if (w_wr_mtval)  r_mtval  <= csr_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Plain software registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mie      <= '0;
      r_mtvec    <= MTVEC_RST[XLEN-1:2];
      r_mscratch <= '0;
    end else begin
      if (w_wr_mie)      r_mie      <= csr_data_i;
      if (w_wr_mtvec)    r_mtvec    <= csr_data_i[XLEN-1:2];
      if (w_wr_mscratch) r_mscratch <= csr_data_i;
    end
  end

  // -------------------------------------------------------------------------
  // Counters: a write to either half replaces that half only and skips the
  // increment for that cycle; otherwise full 64-bit increment with silent
  // wrap.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcycle <= '0;
    end else if (w_wr_mcycle_lo) begin
      r_mcycle[XLEN-1:0] <= csr_data_i;
    end else if (w_wr_mcycle_hi) begin
      r_mcycle[2*XLEN-1:XLEN] <= csr_data_i;
    end else begin
      r_mcycle <= r_mcycle + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_minstret <= '0;
    end else if (w_wr_minstret_lo) begin
      r_minstret[XLEN-1:0] <= csr_data_i;
    end else if (w_wr_minstret_hi) begin
      r_minstret[2*XLEN-1:XLEN] <= csr_data_i;
    end else if (instret_i) begin
      r_minstret <= r_minstret + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Assembled register views
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mtvec;
  logic [XLEN-1:0] w_mepc;

  // Only MPP[12:11], MPIE[7] and MIE[3] exist; the rest reads as zero.
  assign w_mstatus = {{(XLEN-13){1'b0}}, r_mstatus_mpp, 3'b000,
                      r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000};
  assign w_mtvec   = {r_mtvec, 2'b00};
  assign w_mepc    = {r_mepc, 2'b00};

  assign mstatus_q_o = w_mstatus;
  assign mtvec_q_o   = w_mtvec;
  assign mepc_q_o    = w_mepc;

  // -------------------------------------------------------------------------
  // Read port: pure function of current state, no write bypass.
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] w_rd_data;
  logic            w_rd_illegal;

  always_comb begin
    w_rd_data    = '0;
    w_rd_illegal = 1'b0;
    case (csr_rd_adr_i)
      ADR_MSTATUS:   w_rd_data = w_mstatus;
      ADR_MISA:      w_rd_data = MISA_VAL;
      ADR_MIE:       w_rd_data = r_mie;
      ADR_MTVEC:     w_rd_data = w_mtvec;
      ADR_MSCRATCH:  w_rd_data = r_mscratch;
      ADR_MEPC:      w_rd_data = w_mepc;
      ADR_MCAUSE:    w_rd_data = r_mcause;
      ADR_MTVAL:     w_rd_data = r_mtval;
      ADR_MIP:       w_rd_data = '0;
      ADR_MCYCLE,
      ADR_CYCLE:     w_rd_data = r_mcycle[XLEN-1:0];
      ADR_MCYCLEH,
      ADR_CYCLEH:    w_rd_data = r_mcycle[2*XLEN-1:XLEN];
      ADR_MINSTRET,
      ADR_INSTRET:   w_rd_data = r_minstret[XLEN-1:0];
      ADR_MINSTRETH,
      ADR_INSTRETH:  w_rd_data = r_minstret[2*XLEN-1:XLEN];
      ADR_MHARTID:   w_rd_data = HART_ID;
      default:       w_rd_illegal = 1'b1;
    endcase
  end

  assign csr_rd_data_o    = w_rd_data;
  assign csr_rd_illegal_o = w_rd_illegal;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  localparam logic [31:0] P_MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] P_MISA      = 32'h4000_0100;
  localparam logic [31:0] P_HART      = 32'h0000_0005;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        reset;
  logic [11:0] csr_rd_adr_i;
  logic [31:0] csr_rd_data_o;
  logic        csr_rd_illegal_o;
  logic        csr_wbk_v_i;
  logic [11:0] csr_adr_i;
  logic [31:0] csr_data_i;
  logic        exception_i;
  logic [31:0] mcause_i;
  logic [31:0] mtval_i;
  logic [31:0] mepc_i;
  logic [1:0]  core_mode_i;
  logic        instret_i;
  logic [31:0] mstatus_q_o;
  logic [31:0] mtvec_q_o;
  logic [31:0] mepc_q_o;

  initial clk = 1'b0;
  always #50 clk = ~clk;

  csr_file #(
    .XLEN      (32),
    .MTVEC_RST (P_MTVEC_RST),
    .MISA_VAL  (P_MISA),
    .HART_ID   (P_HART)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .csr_rd_adr_i     (csr_rd_adr_i),
    .csr_rd_data_o    (csr_rd_data_o),
    .csr_rd_illegal_o (csr_rd_illegal_o),
    .csr_wbk_v_i      (csr_wbk_v_i),
    .csr_adr_i        (csr_adr_i),
    .csr_data_i       (csr_data_i),
    .exception_i      (exception_i),
    .mcause_i         (mcause_i),
    .mtval_i          (mtval_i),
    .mepc_i           (mepc_i),
    .core_mode_i      (core_mode_i),
    .instret_i        (instret_i),
    .mstatus_q_o      (mstatus_q_o),
    .mtvec_q_o        (mtvec_q_o),
    .mepc_q_o         (mepc_q_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Architectural view: each CSR as a whole word, counters as 64-bit numbers.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;

  task automatic model_reset();
    m_mstatus  = 32'h0000_1800;
    m_mtvec    = P_MTVEC_RST & ~32'h3;
    m_mie      = 0;
    m_mscratch = 0;
    m_mepc     = 0;
    m_mcause   = 0;
    m_mtval    = 0;
    m_mcycle   = 0;
    m_minstret = 0;
  endtask

  // Applies one rising edge worth of architectural effect.
  task automatic model_step();
    bit cyc_written = 0;
    bit ins_written = 0;
    if (exception_i) begin
      m_mepc    = mepc_i & ~32'h3;
      m_mcause  = mcause_i;
      m_mtval   = mtval_i;
      m_mstatus = (32'(core_mode_i) << 11) | (((m_mstatus >> 3) & 32'h1) << 7);
    end else if (csr_wbk_v_i) begin
      case (csr_adr_i)
        12'h300: m_mstatus  = csr_data_i & 32'h0000_1888;
        12'h304: m_mie      = csr_data_i;
        12'h305: m_mtvec    = csr_data_i & ~32'h3;
        12'h340: m_mscratch = csr_data_i;
        12'h341: m_mepc     = csr_data_i & ~32'h3;
        12'h342: m_mcause   = csr_data_i;
        12'h343: m_mtval    = csr_data_i;
        12'hB00: begin m_mcycle   = (m_mcycle   & 64'hFFFF_FFFF_0000_0000) | 64'(csr_data_i); cyc_written = 1; end
        12'hB80: begin m_mcycle   = (m_mcycle   & 64'h0000_0000_FFFF_FFFF) | (64'(csr_data_i) << 32); cyc_written = 1; end
        12'hB02: begin m_minstret = (m_minstret & 64'hFFFF_FFFF_0000_0000) | 64'(csr_data_i); ins_written = 1; end
        12'hB82: begin m_minstret = (m_minstret & 64'h0000_0000_FFFF_FFFF) | (64'(csr_data_i) << 32); ins_written = 1; end
        default: ;
      endcase
    end
    if (!cyc_written) m_mcycle = m_mcycle + 64'd1;
    if (!ins_written && instret_i) m_minstret = m_minstret + 64'd1;
  endtask

  // Returns {illegal, data}.
  function automatic logic [32:0] model_rd(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h301: return {1'b0, P_MISA};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h343: return {1'b0, m_mtval};
      12'h344: return {1'b0, 32'h0};
      12'hB00, 12'hC00: return {1'b0, m_mcycle[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_mcycle[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_minstret[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_minstret[63:32]};
      12'hF14: return {1'b0, P_HART};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // ---------------------------------------------------------------- driver tasks
  logic [11:0] adr_list [0:21];

  task automatic idle_inputs();
    csr_wbk_v_i = 0;
    csr_adr_i   = 0;
    csr_data_i  = 0;
    exception_i = 0;
    mcause_i    = 0;
    mtval_i     = 0;
    mepc_i      = 0;
    core_mode_i = 0;
    instret_i   = 0;
  endtask

  // One rising edge; the model sees the same inputs the DUT sampled.
  task automatic step();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wbk_v_i = 1;
    csr_adr_i   = a;
    csr_data_i  = d;
    step();
    idle_inputs();
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic ill);
    csr_rd_adr_i = a;
    #1;
    d   = csr_rd_data_o;
    ill = csr_rd_illegal_o;
  endtask

  task automatic check_rd(input string tag, input logic [11:0] a);
    logic [31:0] d;
    logic        ill;
    logic [32:0] e;
    rd(a, d, ill);
    e = model_rd(a);
    chk($sformatf("%s_rd_%h", tag, a), {32'h0, d}, {32'h0, e[31:0]});
    chk($sformatf("%s_ill_%h", tag, a), {63'h0, ill}, {63'h0, e[32]});
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 22; i++) check_rd(tag, adr_list[i]);
    chk({tag, "_mstatus_q"}, {32'h0, mstatus_q_o}, {32'h0, m_mstatus});
    chk({tag, "_mtvec_q"},   {32'h0, mtvec_q_o},   {32'h0, m_mtvec});
    chk({tag, "_mepc_q"},    {32'h0, mepc_q_o},    {32'h0, m_mepc});
  endtask

  task automatic check_const(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        ill;
    rd(a, d, ill);
    chk(tag, {32'h0, d}, {32'h0, exp});
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] d;
    logic        ill;
    adr_list = '{12'h300, 12'h301, 12'h304, 12'h344, 12'h305, 12'h340,
                 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80, 12'hB02,
                 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14,
                 12'h7C0, 12'h302, 12'h000, 12'hB01};
    reset        = 1;
    csr_rd_adr_i = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    check_const("rst_mstatus", 12'h300, 32'h0000_1800);
    check_const("rst_mtvec",   12'h305, 32'h0000_1000);
    check_const("rst_hartid",  12'hF14, P_HART);
    rd(12'h7C0, d, ill);
    chk("rst_unimpl_data", {32'h0, d}, 64'h0);
    chk("rst_unimpl_ill",  {63'h0, ill}, 64'h1);
    check_all("rst");

    reset = 0;
    step();
    check_const("first_cycle", 12'hB00, 32'h1);

    // Field masks and RO writes
    wr(12'h300, 32'hFFFF_FFFF);
    check_const("mstatus_mask", 12'h300, 32'h0000_1888);
    wr(12'h305, 32'h8000_0003);
    check_const("mtvec_mask", 12'h305, 32'h8000_0000);
    wr(12'h301, 32'h0);
    check_const("misa_ro", 12'h301, P_MISA);
    check_all("masks");

    // Trap entry with a colliding CSR write
    wr(12'h300, 32'h0000_0008);
    exception_i = 1;
    mepc_i      = 32'h104;
    mcause_i    = 32'h2;
    mtval_i     = 32'h13;
    core_mode_i = 2'b00;
    csr_wbk_v_i = 1;
    csr_adr_i   = 12'h340;
    csr_data_i  = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    check_const("trap_mepc",     12'h341, 32'h104);
    check_const("trap_mcause",   12'h342, 32'h2);
    check_const("trap_mtval",    12'h343, 32'h13);
    check_const("trap_mstatus",  12'h300, 32'h0000_0080);
    check_const("trap_mscratch", 12'h340, 32'h0);
    check_all("trap");

    // mcycle carry into the high half
    wr(12'hB80, 32'h0);
    wr(12'hB00, 32'hFFFF_FFFE);
    repeat (3) step();
    check_const("carry_hi", 12'hB80, 32'h1);
    check_const("carry_lo", 12'hB00, 32'h1);
    check_const("carry_shadow_hi", 12'hC80, 32'h1);
    check_const("carry_shadow_lo", 12'hC00, 32'h1);
    wr(12'hB80, 32'h5);
    check_const("wr_hi", 12'hB80, 32'h5);
    check_const("wr_hi_lo_held", 12'hB00, 32'h1);

    // 64-bit wrap
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFF);
    step();
    check_const("wrap_hi", 12'hB80, 32'h0);
    check_const("wrap_lo", 12'hB00, 32'h0);

    // minstret
    for (int i = 0; i < 20; i++) begin
      instret_i = i[0];
      step();
    end
    instret_i = 0;
    check_const("minstret_10", 12'hB02, 32'd10);
    check_const("instret_10",  12'hC02, 32'd10);
    instret_i = 1;
    wr(12'hB02, 32'h100);
    check_const("minstret_wr_wins", 12'hB02, 32'h100);
    check_all("count");

    // Mid-run asynchronous reset
    repeat (5) step();
    reset = 1;
    model_reset();
    #1;
    check_const("async_rst_mcycle", 12'hB00, 32'h0);
    check_all("async_rst");
    step();
    reset = 0;
    step();
    check_const("resume_mcycle", 12'hB00, 32'h1);
    check_const("resume_minstret", 12'hB02, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      csr_wbk_v_i = ($urandom_range(0, 1) == 1);
      csr_adr_i   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : adr_list[$urandom_range(0, 21)];
      csr_data_i  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      exception_i = ($urandom_range(0, 7) == 0);
      mcause_i    = $urandom;
      mtval_i     = $urandom;
      mepc_i      = $urandom;
      core_mode_i = 2'($urandom_range(0, 3));
      instret_i   = ($urandom_range(0, 1) == 1);
      step();
      idle_inputs();
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR register file that sits directly downstream of the execute stage.
- Consumes the flopped CSR write-back, exception capture and retire information produced by execute.
- Provides a combinational CSR read port to decode.
- Drives mepc/mtvec back to execute for trap entry and return.
- Owns the 64-bit mcycle/minstret counters.

Parameters:
XLEN, 32, data width (only 32 supported)
MTVEC_RST, 32'h0000_0000, mtvec reset value (bits [1:0] forced 0)
MISA_VAL, 32'h4000_0100, read-only misa value (RV32I)
HART_ID, 32'h0, read-only mhartid value

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
csr_rd_adr_i  in  12  CSR read address from decode
csr_rd_data_o  out  XLEN  read data for csr_rd_adr_i, combinational from current state
csr_rd_illegal_o  out  1  high when csr_rd_adr_i is unimplemented
csr_wbk_v_i  in  1  CSR write enable (execute csr_wbk_v_q)
csr_adr_i  in  12  CSR write address
csr_data_i  in  XLEN  CSR write data
exception_i  in  1  trap taken this cycle (execute exception_q)
mcause_i  in  XLEN  trap cause
mtval_i  in  XLEN  trap value
mepc_i  in  XLEN  faulting PC
core_mode_i  in  2  privilege mode before trap (execute core_mode_q)
instret_i  in  1  one instruction retired this cycle
mstatus_q_o  out  XLEN  current mstatus
mtvec_q_o  out  XLEN  current mtvec
mepc_q_o  out  XLEN  current mepc

Behaviour:
- Implemented CSRs (address, access):
  - mstatus 0x300 RW: only MIE[3], MPIE[7] and MPP[12:11] are stored; all other bits read 0.
  - misa 0x301 RO. mie 0x304 RW, full 32 bits. mip 0x344 RO, reads 0.
  - mtvec 0x305 RW: bits [1:0] always 0 (direct mode only).
  - mscratch 0x340 RW. mepc 0x341 RW: bits [1:0] always 0. mcause 0x342 RW. mtval 0x343 RW.
  - mcycle/mcycleh 0xB00/0xB80 RW. minstret/minstreth 0xB02/0xB82 RW.
  - cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82 are RO shadows.
  - mhartid 0xF14 RO.
- Reset, asynchronous and active-high:
  - mstatus = 32'h0000_1800 (MPP=11, MIE=MPIE=0); mtvec = MTVEC_RST & ~3.
  - All other state = 0.
  - Outputs reflect the reset state immediately.
- Read:
  - Purely combinational from register state; no bypass of a same-cycle write (execute forwards).
  - Unimplemented address: data 0, csr_rd_illegal_o=1.
- Write (csr_wbk_v_i=1, exception_i=0):
  - The addressed register updates on the next edge, with field masks applied.
  - Writes to RO or unimplemented addresses are silently ignored.
- Trap entry (exception_i=1), all updated on the same edge:
  - mepc <= mepc_i & ~3; mcause <= mcause_i; mtval <= mtval_i.
  - MPIE <= MIE; MIE <= 0; MPP <= core_mode_i.
- Simultaneous exception_i and csr_wbk_v_i: the trap update wins and the CSR write is dropped entirely.
- mret is not special-cased: execute delivers the restored mstatus as a normal write to 0x300.
- Counters:
  - Each counter is 64 bits, split into lo/hi halves with full carry.
  - mcycle increments by 1 every cycle out of reset; minstret increments when instret_i=1.
  - A write to either half of a counter replaces that half, leaves the other half unchanged, and suppresses that counter's increment for that cycle.
  - Wrap 64'hFFFF_FFFF_FFFF_FFFF -> 0 silently.
- Latency: a write, trap or increment on edge N is visible on the read port and the *_q_o outputs after edge N.

Test Plan:
- Reset, then read 0x300 / 0x305 / 0xF14 / 0x7C0 -> 0x1800, MTVEC_RST&~3, HART_ID, and 0 with illegal=1.
- Write 0x300 = 0xFFFF_FFFF -> reads back 0x0000_1888. Write 0x305 = 0x8000_0003 -> reads 0x8000_0000. Write to 0x301 -> misa unchanged.
- With mstatus=0x0000_0008, pulse exception_i with mepc_i=0x104, mcause_i=2, mtval_i=0x13, core_mode_i=00 -> mepc=0x104, mcause=2, mtval=0x13, mstatus=0x0000_0080. Also assert csr_wbk_v_i to 0x340 in the same cycle -> mscratch unchanged.
- Write mcycle=0xFFFF_FFFE, run 3 cycles -> mcycleh=1, mcycle=1. Write mcycleh=0x5 -> read 0x5 and low half held that cycle. cycle/cycleh shadows match.
- Toggle instret_i 10 of 20 cycles -> minstret=10. Simultaneous write minstret=0x100 with instret_i=1 -> reads 0x100, not 0x101.
- Assert reset mid-run with counters nonzero -> all state returns to reset values immediately. Counting resumes from 0 after release.
